// File: rtl/sar_finder_pkg.sv
// rtl/sar_finder_pkg.sv - shared state encoding and sizing for the SAR search controller
package sar_finder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sarState;

    localparam int DefaultWidth = 4;
    localparam int WorstLatency = DefaultWidth + 2;

endpackage

// File: rtl/sar_finder.sv
// rtl/sar_finder.sv - successive-approximation search driving an external magnitude comparator
// Optional flag consistency checking enabled by defining SAR_FINDER_ERR_EN.
module sar_finder
    import sar_finder_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] TopIdx = IdxW'(WIDTH - 1);

    sarState          state, stateNext;
    logic [WIDTH-1:0] cand, candNext;
    logic [IdxW-1:0]  idx, idxNext;
    logic [WIDTH-1:0] resultNext;
    logic             foundNext, errNext;
    logic [WIDTH-1:0] trialBit;
    logic             flagViolation;

    assign trialBit = WIDTH'(1) << idx;

`ifdef SAR_FINDER_ERR_EN
    assign flagViolation = ({cmp_gt, cmp_lt, cmp_eq} != 3'b100) &&
                           ({cmp_gt, cmp_lt, cmp_eq} != 3'b010) &&
                           ({cmp_gt, cmp_lt, cmp_eq} != 3'b001);
`else
    assign flagViolation = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cand   <= '0;
            idx    <= TopIdx;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= stateNext;
            cand   <= candNext;
            idx    <= idxNext;
            result <= resultNext;
            found  <= foundNext;
            err    <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        candNext   = cand;
        idxNext    = idx;
        resultNext = result;
        foundNext  = found;
        errNext    = err;
        guess      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext  = SEARCH;
                    candNext   = '0;
                    idxNext    = TopIdx;
                    resultNext = '0;
                    foundNext  = 1'b0;
                    errNext    = 1'b0;
                end
            end
            SEARCH: begin
                guess = cand | trialBit;
                if (flagViolation) begin
                    errNext    = 1'b1;
                    foundNext  = 1'b0;
                    resultNext = guess;
                    stateNext  = DONE;
                end else if (cmp_eq) begin
                    resultNext = guess;
                    foundNext  = 1'b1;
                    stateNext  = DONE;
                end else begin
                    // gt leaves the trial bit clear; only a clean lt keeps it
                    if (!cmp_gt && cmp_lt) begin
                        candNext = guess;
                    end
                    if (idx == '0) begin
                        stateNext = VERIFY;
                    end else begin
                        idxNext = idx - 1'b1;
                    end
                end
            end
            VERIFY: begin
                // target 0 is never hit by a trial bit, so confirm the final candidate here
                guess     = cand;
                stateNext = DONE;
                if (flagViolation) begin
                    errNext    = 1'b1;
                    foundNext  = 1'b0;
                    resultNext = guess;
                end else begin
                    resultNext = cand;
                    foundNext  = cmp_eq;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy = (state == SEARCH) || (state == VERIFY);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sar_finder.sv
// tb/tb_sar_finder.sv - directed self-checking bench for sar_finder with a behavioural comparator
module tb_sar_finder;
    import sar_finder_pkg::*;

    localparam int W = DefaultWidth;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] guess;
    logic [W-1:0] result;
    logic [W-1:0] target;
    logic         cmp_gt, cmp_lt, cmp_eq;
    logic         busy, done, found, err;
    logic         forceBoth;

    int           compared = 0;
    int           mismatched = 0;
    logic [W-1:0] guessLog [0:7];
    int           nGuess, doneCycle, doneCount;
    logic [W-1:0] resAtStart;

    always #5 clk = ~clk;

    assign cmp_gt = forceBoth | (guess > target);
    assign cmp_lt = forceBoth | (guess < target);
    assign cmp_eq = !forceBoth && (guess == target);

    sar_finder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .guess  (guess),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic runSearch(input logic [W-1:0] tgt, input logic [15:0] pulseMask, input int forceCycle);
        target    = tgt;
        forceBoth = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        nGuess     = 0;
        doneCycle  = 0;
        doneCount  = 0;
        resAtStart = result;
        for (int c = 1; c <= 12; c++) begin
            forceBoth = (c == forceCycle);
            start     = pulseMask[c];
            if (busy && nGuess < 8) begin
                guessLog[nGuess] = guess;
                nGuess++;
            end
            if (done) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = c;
            end
            @(posedge clk); #1;
        end
        forceBoth = 1'b0;
        start     = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int expN, input logic [31:0] expGuesses,
                            input int expDone, input int expResult, input logic expFound,
                            input logic expErr);
        checkEq({tag, "_nguess"}, nGuess, expN);
        for (int i = 0; i < expN && i < nGuess; i++) begin
            checkEq($sformatf("%s_guess%0d", tag, i), guessLog[i], expGuesses[4*(expN-1-i) +: 4]);
        end
        checkEq({tag, "_done_cycle"}, doneCycle, expDone);
        checkEq({tag, "_done_count"}, doneCount, 1);
        checkEq({tag, "_result_cleared"}, resAtStart, 0);
        checkEq({tag, "_result"}, result, expResult);
        checkEq({tag, "_found"}, found, expFound);
        checkEq({tag, "_err"}, err, expErr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        target    = '0;
        forceBoth = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_guess", guess, 0);
        checkEq("rst_busy", busy, 0);
        checkEq("rst_done", done, 0);
        checkEq("rst_result", result, 0);
        checkEq("rst_found", found, 0);
        checkEq("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        runSearch(4'd5, 16'h0000, 0);
        checkRun("t5", 4, 32'h8465, 5, 5, 1'b1, 1'b0);
        runSearch(4'd0, 16'h0000, 0);
        checkRun("t0", 5, 32'h84210, WorstLatency, 0, 1'b1, 1'b0);
        runSearch(4'd8, 16'h0000, 0);
        checkRun("t8", 1, 32'h8, 2, 8, 1'b1, 1'b0);
        runSearch(4'd15, 16'h0000, 0);
        checkRun("t15", 4, 32'h8cef, 5, 15, 1'b1, 1'b0);
        runSearch(4'd5, 16'h001c, 0);
        checkRun("pulse", 4, 32'h8465, 5, 5, 1'b1, 1'b0);

        target = 4'd9;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkEq("rst9_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        checkEq("rst9_guess", guess, 0);
        checkEq("rst9_busy", busy, 0);
        checkEq("rst9_done", done, 0);
        checkEq("rst9_result", result, 0);
        checkEq("rst9_found", found, 0);
        checkEq("rst9_err", err, 0);
        doneCount = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) doneCount++;
        end
        checkEq("rst9_no_done", doneCount, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        runSearch(4'd9, 16'h0000, 0);
        checkRun("t9", 4, 32'h8ca9, 5, 9, 1'b1, 1'b0);

`ifdef SAR_FINDER_ERR_EN
        runSearch(4'd6, 16'h0000, 2);
        checkRun("flags_err", 2, 32'h84, 3, 4, 1'b0, 1'b1);
`else
        runSearch(4'd6, 16'h0000, 2);
        checkRun("flags_gt", 5, 32'h84233, 6, 3, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
